// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU decode/execute slice:
//   alu_ctrl_t   - 4-bit ALU control encoding driven onto alu_ctrl
//   ALU_OP_*     - main-decoder class values presented on alu_op
//   OP_R / OP_I  - major opcodes for register and immediate ALU instructions
//   FUNCT7_*     - funct7 values that select MUL and the alternate (SUB/SRA) form
//   state_t      - execute FSM states
// ----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MUL  = 4'b1010
  } alu_ctrl_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_ILL   = 2'b11;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  // Bit 5 of funct7 selects the alternate form (SUB for add, SRA for srl).
  function automatic logic is_alt(input logic [6:0] f7);
    return f7[5];
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// ----------------------------------------------------------------------------
// alu_ctrl_dec
// Purely combinational ALU control decoder.
//   op       in  7  major opcode
//   funct3   in  3  instruction funct3
//   funct7   in  7  instruction funct7
//   alu_op   in  2  main-decoder class
//   alu_ctrl out 4  decoded ALU operation (ALU_ADD when illegal)
//   illegal  out 1  instruction cannot be executed
// Parameter EN_MUL: 1 enables MUL decode, 0 reports MUL as illegal.
// ----------------------------------------------------------------------------
module alu_ctrl_dec
  import alu_pkg::*;
#(
  parameter int unsigned EN_MUL = 1
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [1:0] alu_op,
  output alu_ctrl_t  alu_ctrl,
  output logic       illegal
);

  // Decode class first, then funct3/funct7 for the register/immediate class.
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    unique case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      ALU_OP_FUNCT: begin
        if (funct7 == FUNCT7_MUL) begin
          // Only the register-form funct3=000 slot of the M encoding is supported.
          if ((EN_MUL != 0) && (op == OP_R) && (funct3 == 3'b000)) begin
            alu_ctrl = ALU_MUL;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          case (funct3)
            3'b000: alu_ctrl = (op[5] && is_alt(funct7)) ? ALU_SUB : ALU_ADD;
            3'b001: alu_ctrl = ALU_SLL;
            3'b010: alu_ctrl = ALU_SLT;
            3'b011: alu_ctrl = ALU_SLTU;
            3'b100: alu_ctrl = ALU_XOR;
            3'b101: alu_ctrl = is_alt(funct7) ? ALU_SRA : ALU_SRL;
            3'b110: alu_ctrl = ALU_OR;
            3'b111: alu_ctrl = ALU_AND;
          endcase
        end
      end
      ALU_OP_ILL: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_decode_exec.sv
// ----------------------------------------------------------------------------
// alu_decode_exec
// Decodes an ALU instruction and executes it. Single-cycle operations
// register their result one cycle after acceptance; MUL runs an iterative
// shift-add multiplier for XLEN cycles. Results are held until the consumer
// takes them.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   op/funct3/funct7    instruction fields
//   alu_op              main-decoder class
//   src_a/src_b         XLEN-bit operands
//   out_valid/out_ready output handshake
//   result/zero         registered result and result==0 flag
//   alu_ctrl/illegal    registered decoded operation and illegal flag
// ----------------------------------------------------------------------------
module alu_decode_exec
  import alu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned EN_MUL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [1:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_ctrl_t       dec_ctrl;
  logic            dec_illegal;

  state_t          state;
  state_t          next_state;

  logic            accept_c;
  logic            start_mul_c;
  logic            mul_last_c;
  logic [SHW-1:0]  shamt;
  logic [SHW-1:0]  mul_cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [XLEN-1:0] exec_res;

  alu_ctrl_dec #(
    .EN_MUL (EN_MUL)
  ) u_dec (
    .op       (op),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_op   (alu_op),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  assign shamt       = src_b[SHW-1:0];
  assign accept_c    = in_valid && in_ready;
  assign start_mul_c = (dec_ctrl == ALU_MUL) && !dec_illegal;
  assign mul_last_c  = (mul_cnt == SHW'(XLEN - 1));
  assign acc_next    = mplier[0] ? (acc + mcand) : acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (accept_c) next_state = start_mul_c ? S_MUL : S_HOLD;
      end
      S_MUL: begin
        if (mul_last_c) next_state = S_HOLD;
      end
      S_HOLD: begin
        // A new op can replace the held result in the same cycle it drains.
        if (accept_c) begin
          next_state = start_mul_c ? S_MUL : S_HOLD;
        end else if (out_ready) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      S_IDLE:  in_ready = 1'b1;
      S_HOLD:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Single-cycle execute; illegal ops produce zero.
  always_comb begin
    exec_res = '0;
    if (!dec_illegal) begin
      unique case (dec_ctrl)
        ALU_ADD:  exec_res = src_a + src_b;
        ALU_SUB:  exec_res = src_a - src_b;
        ALU_OR:   exec_res = src_a | src_b;
        ALU_AND:  exec_res = src_a & src_b;
        ALU_XOR:  exec_res = src_a ^ src_b;
        ALU_SLL:  exec_res = src_a << shamt;
        ALU_SRL:  exec_res = src_a >> shamt;
        ALU_SRA:  exec_res = XLEN'($signed(src_a) >>> shamt);
        ALU_SLT:  exec_res = XLEN'($signed(src_a) < $signed(src_b));
        ALU_SLTU: exec_res = XLEN'(src_a < src_b);
        default:  exec_res = '0;
      endcase
    end
  end

  // Multiplier operand/accumulator registers and the held output payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      mul_cnt  <= '0;
      result   <= '0;
      zero     <= 1'b0;
      alu_ctrl <= 4'b0000;
      illegal  <= 1'b0;
    end else if (accept_c) begin
      if (start_mul_c) begin
        mcand   <= src_a;
        mplier  <= src_b;
        acc     <= '0;
        mul_cnt <= '0;
      end else begin
        result   <= exec_res;
        zero     <= (exec_res == '0);
        alu_ctrl <= 4'(dec_ctrl);
        illegal  <= dec_illegal;
      end
    end else if (state == S_MUL) begin
      // One multiplier bit per cycle, LSB first; carries past XLEN are dropped.
      acc     <= acc_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      mul_cnt <= mul_cnt + SHW'(1);
      if (mul_last_c) begin
        result   <= acc_next;
        zero     <= (acc_next == '0);
        alu_ctrl <= 4'(ALU_MUL);
        illegal  <= 1'b0;
      end
    end
  end

  // out_valid tracks the HOLD state one register stage ahead of decoding it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= (next_state == S_HOLD);
    end
  end

endmodule

// File: tb/tb_alu_decode_exec.sv
// ----------------------------------------------------------------------------
// tb_alu_decode_exec
// Scoreboard bench: the driver pushes the expected response of every accepted
// instruction; the monitor compares the front entry whenever out_valid is
// high and pops it on out_ready.
// ----------------------------------------------------------------------------
module tb_alu_decode_exec;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic [3:0]  ctrl;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  alu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  alu_ctrl;
  logic        illegal;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   rnd_bp = 1'b0;
  exp_t q[$];

  alu_decode_exec #(
    .XLEN   (32),
    .EN_MUL (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_op    (alu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic [3:0] c, input logic i);
    exp_t e;
    e.result = r;
    e.zero   = z;
    e.ctrl   = c;
    e.ill    = i;
    return e;
  endfunction

  // Reference behaviour straight from the decode table and arithmetic rules.
  function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [1:0] ao, input logic [31:0] a, input logic [31:0] b);
    int unsigned       sh;
    longint unsigned   prod;
    logic [3:0]        c;
    logic              ill;
    logic [31:0]       r;
    sh  = b % 32;
    c   = 4'd0;
    ill = 1'b0;
    r   = 32'd0;
    if (ao == 2'b00)      c = 4'd0;
    else if (ao == 2'b01) c = 4'd1;
    else if (ao == 2'b11) ill = 1'b1;
    else if (f7 == 7'b0000001) begin
      if (o == 7'b0110011 && f3 == 3'd0) c = 4'd10;
      else ill = 1'b1;
    end else begin
      case (f3)
        3'd0: c = (o[5] && f7[5]) ? 4'd1 : 4'd0;
        3'd1: c = 4'd5;
        3'd2: c = 4'd8;
        3'd3: c = 4'd9;
        3'd4: c = 4'd4;
        3'd5: c = f7[5] ? 4'd7 : 4'd6;
        3'd6: c = 4'd2;
        3'd7: c = 4'd3;
      endcase
    end
    case (c)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a | b;
      4'd3:  r = a & b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7:  r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin
        prod = 64'(a) * 64'(b);
        r    = prod[31:0];
      end
      default: r = 32'd0;
    endcase
    if (ill) begin
      r = 32'd0;
      c = 4'd0;
    end
    return mk(r, (r == 32'd0), c, ill);
  endfunction

  // Monitor: compare while presented, retire on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got result %0h with empty scoreboard", result);
      end else begin
        check("out_payload", {26'd0, result, zero, alu_ctrl, illegal}, {26'd0, q[0]});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [1:0] ao, input logic [31:0] a, input logic [31:0] b,
                       input bit use_exp, input exp_t e, output int waited);
    bit done;
    in_valid = 1'b1;
    op       = o;
    funct3   = f3;
    funct7   = f7;
    alu_op   = ao;
    src_a    = a;
    src_b    = b;
    waited   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(use_exp ? e : model(o, f3, f7, ao, a, b));
        tick();
        done = 1'b1;
      end else begin
        tick();
        waited++;
        if (waited > 500) begin
          n_cmp++;
          n_fail++;
          $display("FAIL accept_timeout: got no in_ready after %0d cycles, expected acceptance", waited);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int          w;
    int          bad;
    logic [6:0]  ro;
    logic [2:0]  rf3;
    logic [6:0]  rf7;
    logic [1:0]  rao;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t        none;

    none      = mk(32'd0, 1'b0, 4'd0, 1'b0);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 7'd0;
    funct3    = 3'd0;
    funct7    = 7'd0;
    alu_op    = 2'd0;
    src_a     = 32'd0;
    src_b     = 32'd0;
    out_ready = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_zero",      64'(zero),      64'd0);
    check("rst_alu_ctrl",  64'(alu_ctrl),  64'd0);
    check("rst_illegal",   64'(illegal),   64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // SUB 5-7 with back-pressure: held stable, no acceptance.
    out_ready = 1'b0;
    issue(OP_R, 3'b000, FUNCT7_ALT, 2'b10, 32'd5, 32'd7, 1'b1,
          mk(32'hFFFF_FFFE, 1'b0, 4'b0001, 1'b0), w);
    repeat (5) begin
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready",  64'(in_ready),  64'd0);
    end
    tick();
    out_ready = 1'b1;
    issue(OP_R, 3'b000, 7'd0, 2'b10, 32'd2, 32'd2, 1'b1, mk(32'd4, 1'b0, 4'b0000, 1'b0), w);
    check("b2b_accept_wait", 64'(w), 64'd0);

    // Shifts: arithmetic vs logical.
    issue(OP_R, 3'b101, FUNCT7_ALT, 2'b10, 32'h8000_0000, 32'd4, 1'b1,
          mk(32'hF800_0000, 1'b0, 4'b0111, 1'b0), w);
    issue(OP_R, 3'b101, 7'd0, 2'b10, 32'h8000_0000, 32'd4, 1'b1,
          mk(32'h0800_0000, 1'b0, 4'b0110, 1'b0), w);

    // MUL latency and busy window.
    issue(OP_R, 3'b000, FUNCT7_MUL, 2'b10, 32'hFFFF_FFFF, 32'd3, 1'b1,
          mk(32'hFFFF_FFFD, 1'b0, 4'b1010, 1'b0), w);
    bad = 0;
    repeat (32) begin
      @(negedge clk);
      if (in_ready || out_valid) bad++;
    end
    check("mul_busy_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    check("mul_valid_at_33", 64'(out_valid), 64'd1);
    tick();

    // Illegal class.
    issue(OP_R, 3'b000, 7'd0, 2'b11, 32'd9, 32'd9, 1'b1, mk(32'd0, 1'b1, 4'b0000, 1'b1), w);
    repeat (2) tick();

    // Reset in the middle of a MUL.
    issue(OP_R, 3'b000, FUNCT7_MUL, 2'b10, $urandom, $urandom, 1'b0, none, w);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmul_rst_out_valid", 64'(out_valid), 64'd0);
    check("midmul_rst_result",    64'(result),    64'd0);
    check("midmul_rst_alu_ctrl",  64'(alu_ctrl),  64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("midmul_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("midmul_no_stale", 64'(bad), 64'd0);
    tick();

    // Randomised traffic with random back-pressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       ro = OP_R;
        1:       ro = OP_I;
        default: ro = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       rf7 = 7'd0;
        1:       rf7 = FUNCT7_ALT;
        2:       rf7 = FUNCT7_MUL;
        default: rf7 = 7'($urandom);
      endcase
      rf3 = 3'($urandom);
      rao = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
      case ($urandom_range(0, 5))
        0:       ra = 32'd0;
        1:       ra = 32'h8000_0000;
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        ro  = OP_R;
        rf3 = 3'b000;
        rf7 = FUNCT7_MUL;
        rao = 2'b10;
      end
      issue(ro, rf3, rf7, rao, ra, rb, 1'b0, none, w);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    // Drain the scoreboard.
    rnd_bp    = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (q.size() != 0 && w < 500) begin
      tick();
      w++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
